// File: rtl/p09_pkg.sv
// Purpose : shared VGA timing constants (640x480@60 defaults), derived totals, coordinate types.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package p09_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [5:0]         rgb_t;

    // Inclusive window test used for the sync pulse ranges.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/p09_wrap_counter.sv
// Purpose : modulo-MODULUS up counter with enable; exposes current and next value plus wrap strobe.
// Latency : count updates on the edge after en_i; nxt_o/wrap_o are combinational.
// Backpressure: none; en_i simply holds the count.
module p09_wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o
);

    // Resetting to the last value makes the first enabled edge land on 0.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_last;

    // Next count: advance when enabled, fold back to 0 after LAST.
    always_comb begin
        at_last = (cnt_q == LAST);
        wrap_o  = en_i && at_last;
        cnt_d   = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register with asynchronous reset to LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/p09_vga_timing.sv
// Purpose : VGA raster generator: x/y counters, frame flags, active-low syncs and blanked colour.
// Latency : flags coincide with x,y; hsync_o/vsync_o/rgb_o trail x,y by exactly 1 clk.
// Backpressure: none; free-running at the pixel clock.
module p09_vga_timing
    import p09_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               in_frame,
    output logic               line_start,
    output logic               frame_start,
    input  logic [5:0]         pix_in,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [5:0]         rgb_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t x_cnt;
    coord_t x_nxt;
    coord_t y_cnt;
    coord_t y_nxt;
    logic   x_wrap;
    logic   y_wrap;

    // Stage 1 state: raster flags aligned with the counters.
    logic in_frame_q;
    logic in_frame_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;

    // Stage 2 state: display-facing signals, one clock behind x,y.
    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    rgb_t rgb_q;
    rgb_t rgb_d;

    p09_wrap_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (H_TOTAL)
    ) u_x_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .cnt_o  (x_cnt),
        .nxt_o  (x_nxt),
        .wrap_o (x_wrap)
    );

    p09_wrap_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (V_TOTAL)
    ) u_y_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (x_wrap),
        .cnt_o  (y_cnt),
        .nxt_o  (y_nxt),
        .wrap_o (y_wrap)
    );

    // Flags from next-state counts; x wrapping means next x==0, and y wrapping
    // (only possible while x wraps) means next x==0 and y==0.
    always_comb begin
        in_frame_d    = (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
        line_start_d  = x_wrap;
        frame_start_d = y_wrap;
    end

    // Stage 1 flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            in_frame_q    <= in_frame_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Syncs decoded from the current position; colour blanked outside the active area.
    always_comb begin
        hsync_d = ~in_window(x_cnt, HS_FIRST, HS_LAST);
        vsync_d = ~in_window(y_cnt, VS_FIRST, VS_LAST);
        rgb_d   = in_frame_q ? pix_in : '0;
    end

    // Stage 2 output registers; syncs idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign x           = x_cnt;
    assign y           = y_cnt;
    assign in_frame    = in_frame_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign rgb_o       = rgb_q;

endmodule

// File: tb/tb_p09_vga_timing.sv
// Purpose : scoreboard bench for p09_vga_timing, default timing plus a shrunken raster for whole frames.
// Latency : expectations are queued one edge ahead and popped after that edge.
// Backpressure: n/a.
module tb_p09_vga_timing;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;

    localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;
    localparam int BVA = 12, BVF = 2, BVS = 3, BVB = 3;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       inf;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] pix_in;

    logic [9:0] xa, ya, xb, yb;
    logic       ifa, lsa, fsa, hsa, vsa;
    logic       ifb, lsb, fsb, hsb, vsb;
    logic [5:0] rgba, rgbb;

    obs_t obs_a, obs_b;
    assign obs_a = {xa, ya, ifa, lsa, fsa, hsa, vsa, rgba};
    assign obs_b = {xb, yb, ifb, lsb, fsb, hsb, vsb, rgbb};

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   n      = 0;

    always #5 clk = ~clk;

    p09_vga_timing dut_a (
        .clk         (clk),
        .rst         (rst),
        .x           (xa),
        .y           (ya),
        .in_frame    (ifa),
        .line_start  (lsa),
        .frame_start (fsa),
        .pix_in      (pix_in),
        .hsync_o     (hsa),
        .vsync_o     (vsa),
        .rgb_o       (rgba)
    );

    p09_vga_timing #(
        .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
        .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .x           (xb),
        .y           (yb),
        .in_frame    (ifb),
        .line_start  (lsb),
        .frame_start (fsb),
        .pix_in      (pix_in),
        .hsync_o     (hsb),
        .vsync_o     (vsb),
        .rgb_o       (rgbb)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Reference: state after edge n+1 following reset release, from raster arithmetic.
    // Display outputs reflect the position one edge earlier (reset position for n==0).
    function automatic obs_t model(input int nn, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input logic [5:0] pix);
        int   ht = ha + hf + hs + hb;
        int   vt = va + vf + vs + vb;
        int   cx, cy, px, py;
        bit   pin;
        obs_t e;
        cx    = nn % ht;
        cy    = (nn / ht) % vt;
        e.x   = 10'(cx);
        e.y   = 10'(cy);
        e.inf = (cx < ha) && (cy < va);
        e.ls  = (cx == 0);
        e.fs  = (cx == 0) && (cy == 0);
        if (nn == 0) begin
            px  = ht - 1;
            py  = vt - 1;
            pin = 1'b0;
        end else begin
            px  = (nn - 1) % ht;
            py  = ((nn - 1) / ht) % vt;
            pin = (px < ha) && (py < va);
        end
        e.hs  = !((px >= ha + hf) && (px < ha + hf + hs));
        e.vs  = !((py >= va + vf) && (py < va + vf + vs));
        e.rgb = pin ? pix : 6'h00;
        return e;
    endfunction

    // Drive one pixel, queue what both DUTs must show after the coming edge.
    task automatic step(input logic [5:0] p);
        exp_t e;
        pix_in = p;
        e.a = model(n, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, p);
        e.b = model(n, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, p);
        q.push_back(e);
        @(posedge clk);
        #2;
        n++;
    endtask

    task automatic check_reset(input string tag);
        obs_t ra, rb;
        ra = {10'(AHT - 1), 10'(AVT - 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00};
        rb = {10'(BHT - 1), 10'(BVT - 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00};
        chk({tag, "_a"}, longint'(obs_a), longint'(ra));
        chk({tag, "_b"}, longint'(obs_b), longint'(rb));
    endtask

    // Monitor: pop and compare after every active edge; also measure pulse widths and strobe spacing.
    initial begin
        exp_t e;
        int   cyc   = 0;
        int   hlow  = 0;
        int   vlow  = 0;
        int   lastl = -1;
        int   lastf = -1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hlow  = 0;
                vlow  = 0;
                lastl = -1;
                lastf = -1;
            end else begin
                cyc++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("raster_a", longint'(obs_a), longint'(e.a));
                    chk("raster_b", longint'(obs_b), longint'(e.b));
                end
                if (!hsa) begin
                    hlow++;
                end else if (hlow > 0) begin
                    chk("hsync_low_len_a", hlow, AHS);
                    hlow = 0;
                end
                if (!vsb) begin
                    vlow++;
                end else if (vlow > 0) begin
                    chk("vsync_low_len_b", vlow, BVS * BHT);
                    vlow = 0;
                end
                if (lsa) begin
                    if (lastl >= 0) chk("line_start_period_a", cyc - lastl, AHT);
                    lastl = cyc;
                end
                if (fsb) begin
                    if (lastf >= 0) chk("frame_start_period_b", cyc - lastf, BHT * BVT);
                    lastf = cyc;
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pix_in = 6'h00;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset_hold");

        // Random colours over several lines (A) and frames (B).
        rst = 1'b0;
        n   = 0;
        repeat (3000) step(6'($urandom));

        // Walk A to x==300, then reset mid-frame and check before any edge.
        while (((n - 1) % AHT) != 300) step(6'($urandom));
        chk("pre_reset_x_a", xa, 300);
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        check_reset("reset_hold2");

        // Restart with constant full-white colour.
        rst = 1'b0;
        n   = 0;
        repeat (2000) step(6'h3F);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
